// File: rtl/wdt_kicker_pkg.sv
// Shared constants and FSM state type for the watchdog kicker.
// Optional readback verification of start is enabled by WDT_KICKER_READBACK_EN.
package wdt_kicker_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_START  = 2;
    localparam int STAT_TO     = 0;
    localparam int STAT_RUN    = 1;

    localparam logic [15:0] CTRL_GO = 16'((1 << CTRL_IRQ_EN) | (1 << CTRL_START));

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_KICK,
        S_CLR,
        S_RD,
        S_RD_WAIT,
        S_RD_CHK
    } wdt_state_e;

endpackage

// File: rtl/wdt_kick_timer.sv
// Reloading 32-bit down-counter; zero pulses for the cycle the count is 0.
module wdt_kick_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] load_val,
    output logic        zero
);

    logic [31:0] cnt;

    assign zero = en && !load && (cnt == 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 32'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= (cnt == 32'd0) ? load_val : cnt - 32'd1;
        end
    end

endmodule

// File: rtl/wdt_kicker_ctrl.sv
// Avalon-MM master that starts, kicks and services the system watchdog.
// Define WDT_KICKER_READBACK_EN to verify start via a STATUS read.
module wdt_kicker_ctrl
    import wdt_kicker_pkg::*;
#(
    parameter int NUM_HB      = 4,
    parameter int KICK_CYCLES = 50000000,
    parameter int MISS_LIMIT  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_HB-1:0] hb,
    output logic [2:0]        wdt_address,
    output logic              wdt_chipselect,
    output logic              wdt_write_n,
    output logic [15:0]       wdt_writedata,
    input  logic [15:0]       wdt_readdata,
    input  logic              wdt_irq,
    output logic              running,
    output logic              kick_pulse,
    output logic              hb_fault,
    output logic [NUM_HB-1:0] missed_mask,
    output logic [7:0]        timeout_count
`ifdef WDT_KICKER_READBACK_EN
    ,
    output logic              start_fail
`endif
);

    wdt_state_e        state, state_d;
    logic              kick_due, kick_due_d;
    logic [NUM_HB-1:0] seen_mask, seen_d, missed_d;
    logic              seen_clr;
    logic [3:0]        miss_cnt, miss_cnt_d, miss_nxt;
    logic              fault_d, running_d, go_clr;
    logic [7:0]        tcount_d;
    logic              irq_armed, irq_armed_d;
    logic              cs_d, wn_d;
    logic [2:0]        addr_d;
    logic [15:0]       data_d;
    logic              in_run, tmr_load, tmr_zero;

`ifdef WDT_KICKER_READBACK_EN
    logic [1:0] tries, tries_d;
    logic       fail_d;
`else
    logic       unused_rd;
    assign unused_rd = ^wdt_readdata;
`endif

    assign in_run   = (state == S_RUN) || (state == S_KICK) || (state == S_CLR);
    assign tmr_load = (state_d == S_RUN) && !in_run;
    assign miss_nxt = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;

    wdt_kick_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .en       (in_run),
        .load_val (32'(KICK_CYCLES - 1)),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state;
        kick_due_d = kick_due | tmr_zero;
        seen_clr   = 1'b0;
        miss_cnt_d = miss_cnt;
        missed_d   = missed_mask;
        fault_d    = hb_fault;
        running_d  = running;
        tcount_d   = timeout_count;
        go_clr     = 1'b0;
`ifdef WDT_KICKER_READBACK_EN
        tries_d    = tries;
        fail_d     = start_fail;
`endif
        unique case (state)
            S_IDLE: begin
`ifdef WDT_KICKER_READBACK_EN
                if (enable && !start_fail) state_d = S_START;
`else
                if (enable) state_d = S_START;
`endif
            end
            S_START: begin
                running_d = 1'b1;
`ifdef WDT_KICKER_READBACK_EN
                state_d = S_RD;
`else
                state_d = S_RUN;
`endif
            end
            S_RUN: begin
                // IRQ service wins; a pending kick waits until we return
                if (wdt_irq && irq_armed) begin
                    state_d = S_CLR;
                    go_clr  = 1'b1;
                end else if (kick_due) begin
                    kick_due_d = tmr_zero;
                    seen_clr   = 1'b1;
                    if (enable && (&seen_mask) && !hb_fault) begin
                        state_d    = S_KICK;
                        miss_cnt_d = 4'd0;
                    end else if (enable && !(&seen_mask)) begin
                        missed_d   = ~seen_mask;
                        miss_cnt_d = miss_nxt;
                        if (miss_nxt >= 4'(MISS_LIMIT)) fault_d = 1'b1;
                    end
                end
            end
            S_KICK: begin
                state_d = S_RUN;
            end
            S_CLR: begin
                if (timeout_count != 8'hFF) tcount_d = timeout_count + 8'd1;
                state_d = S_RUN;
            end
`ifdef WDT_KICKER_READBACK_EN
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_d = S_RD_CHK;
            end
            S_RD_CHK: begin
                if (wdt_readdata[STAT_RUN]) begin
                    state_d = S_RUN;
                end else if (tries == 2'd2) begin
                    fail_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tries_d = tries + 2'd1;
                    state_d = S_START;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign seen_d      = (seen_clr ? '0 : seen_mask) | hb;
    assign irq_armed_d = !wdt_irq || (irq_armed && !go_clr);

    // Bus outputs are registered from the next state so they align with it
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = REG_STATUS;
        data_d = 16'h0000;
        unique case (state_d)
            S_START: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = REG_CONTROL;
                data_d = CTRL_GO;
            end
            S_KICK: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = REG_PERIOD_L;
            end
            S_CLR: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = REG_STATUS;
            end
            S_RD: begin
                cs_d   = 1'b1;
                addr_d = REG_STATUS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            kick_due       <= 1'b0;
            seen_mask      <= '0;
            missed_mask    <= '0;
            miss_cnt       <= 4'd0;
            hb_fault       <= 1'b0;
            running        <= 1'b0;
            timeout_count  <= 8'd0;
            irq_armed      <= 1'b0;
            kick_pulse     <= 1'b0;
            wdt_chipselect <= 1'b0;
            wdt_write_n    <= 1'b1;
            wdt_address    <= 3'd0;
            wdt_writedata  <= 16'h0000;
        end else begin
            state          <= state_d;
            kick_due       <= kick_due_d;
            seen_mask      <= seen_d;
            missed_mask    <= missed_d;
            miss_cnt       <= miss_cnt_d;
            hb_fault       <= fault_d;
            running        <= running_d;
            timeout_count  <= tcount_d;
            irq_armed      <= irq_armed_d;
            kick_pulse     <= (state_d == S_KICK);
            wdt_chipselect <= cs_d;
            wdt_write_n    <= wn_d;
            wdt_address    <= addr_d;
            wdt_writedata  <= data_d;
        end
    end

`ifdef WDT_KICKER_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tries      <= 2'd0;
            start_fail <= 1'b0;
        end else begin
            tries      <= tries_d;
            start_fail <= fail_d;
        end
    end
`endif

endmodule
